// File: rtl/arb_pkg.sv
// Shared types and helpers for the packet round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Wrapping increment for non-power-of-two requester counts.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr == n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Round-robin pick: first valid requester at or after ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] win,
    output logic [N-1:0]  win_oh,
    output logic          any
);

    logic [N-1:0]   mask;
    logic [2*N-1:0] dbl;

    // Lower half holds requesters at or above ptr; upper half supplies the wrap.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        dbl = {req, req & mask};
        win = '0;
        any = 1'b0;
        for (int j = 2*N-1; j >= 0; j--) begin
            if (dbl[j]) begin
                any = 1'b1;
                win = (j >= N) ? PW'(j - N) : PW'(j);
            end
        end
        win_oh = any ? (N'(1) << win) : '0;
    end

endmodule

// File: rtl/arb_rr_pkt.sv
// Packet-granular round-robin arbiter: one source owns the output from first offer to last beat.
// Latency: zero-cycle combinational path from req_* to out_*; next arbitration one cycle after a last beat.
// Backpressure: out_rdy is passed to the owner only; an offered beat locks its source so out_* stay stable.
module arb_rr_pkt
    import arb_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 32,
    localparam int PW = $clog2(N)
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic [N-1:0]   req_vld,
    input  logic [N*W-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_rdy,
    output logic           out_vld,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic [N-1:0]   out_gnt,
    input  logic           out_rdy,
    output logic           busy
);

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] pick_win;
    logic [N-1:0]  pick_oh;
    logic          pick_any;
    logic [PW-1:0] sel;

    arb_rr_pick #(.N(N)) u_pick (
        .req    (req_vld),
        .ptr    (ptr),
        .win    (pick_win),
        .win_oh (pick_oh),
        .any    (pick_any)
    );

    always_comb begin
        sel      = (state == LOCKED) ? owner : pick_win;
        out_data = req_data[int'(sel)*W +: W];
        out_last = req_last[sel];
        if (state == LOCKED) begin
            out_vld = req_vld[owner];
            out_gnt = req_vld[owner] ? (N'(1) << owner) : '0;
        end else begin
            out_vld = pick_any;
            out_gnt = pick_oh;
        end
        req_rdy = out_rdy ? out_gnt : '0;
        busy    = (state == LOCKED);
    end

    // Any offered beat that is not a completed single-beat packet locks its source.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        if (out_rdy && out_last) begin
                            ptr <= PW'(rr_next(32'(pick_win), N));
                        end else begin
                            state <= LOCKED;
                            owner <= pick_win;
                        end
                    end
                end
                LOCKED: begin
                    if (req_vld[owner] && out_rdy && req_last[owner]) begin
                        state <= IDLE;
                        ptr   <= PW'(rr_next(32'(owner), N));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!arst_n) $onehot0(out_gnt));
    a_rdy_onehot: assert property (@(posedge clk) disable iff (!arst_n) $onehot0(req_rdy));
    a_data_hold:  assert property (@(posedge clk) disable iff (!arst_n)
                                   (out_vld && !out_rdy) |=> $stable(out_data));

endmodule

// File: tb/tb_arb_rr_pkt.sv
// Bench for arb_rr_pkt: directed ordering on N=4 and N=3 builds, then random traffic vs a reference model.
module tb_arb_rr_pkt;

    localparam int N    = 4;
    localparam int W    = 32;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    logic [N-1:0]   req_vld, req_last, req_rdy, out_gnt;
    logic [N*W-1:0] req_data;
    logic           out_vld, out_last, out_rdy, busy;
    logic [W-1:0]   out_data;

    logic [2:0]  n3_req_vld, n3_req_last, n3_req_rdy, n3_out_gnt;
    logic [23:0] n3_req_data;
    logic        n3_out_vld, n3_out_last, n3_out_rdy, n3_busy;
    logic [7:0]  n3_out_data;

    arb_rr_pkt #(.N(N), .W(W)) dut (
        .clk(clk), .arst_n(arst_n),
        .req_vld(req_vld), .req_data(req_data), .req_last(req_last), .req_rdy(req_rdy),
        .out_vld(out_vld), .out_data(out_data), .out_last(out_last), .out_gnt(out_gnt),
        .out_rdy(out_rdy), .busy(busy)
    );

    arb_rr_pkt #(.N(3), .W(8)) dut3 (
        .clk(clk), .arst_n(arst_n),
        .req_vld(n3_req_vld), .req_data(n3_req_data), .req_last(n3_req_last), .req_rdy(n3_req_rdy),
        .out_vld(n3_out_vld), .out_data(n3_out_data), .out_last(n3_out_last), .out_gnt(n3_out_gnt),
        .out_rdy(n3_out_rdy), .busy(n3_busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: arbitration state expressed as plain integers.
    int m_ptr;
    bit m_lock;
    int m_owner;
    int rem_len [N];
    bit sb_in_pkt;
    int sb_src;

    task automatic reset_model();
        m_ptr     = 0;
        m_lock    = 0;
        m_owner   = 0;
        sb_in_pkt = 0;
        sb_src    = 0;
        for (int i = 0; i < N; i++) rem_len[i] = $urandom_range(1, 4);
        req_vld  = '0;
        req_last = '0;
        req_data = '0;
    endtask

    // Requesters obey the hold-until-ready rule; a new beat is offered with 2/3 probability.
    task automatic gen_inputs();
        for (int i = 0; i < N; i++) begin
            if (!req_vld[i] && $urandom_range(0, 2) != 0) begin
                req_vld[i]          = 1'b1;
                req_data[i*W +: W]  = $urandom;
                req_last[i]         = (rem_len[i] == 1);
            end
        end
        out_rdy = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        reset_model();
        out_rdy = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_vld",  out_vld, 0);
        check("rst_gnt",  out_gnt, 0);
        check("rst_rdy",  req_rdy, 0);
        #1;
        arst_n = 1'b1;
    endtask

    task automatic step3(input logic [2:0] vld, input logic [2:0] last, input logic rdy,
                         input logic [2:0] exp_gnt, input logic exp_busy);
        n3_req_vld  = vld;
        n3_req_last = last;
        n3_out_rdy  = rdy;
        @(negedge clk);
        check("n3_gnt",  n3_out_gnt, exp_gnt);
        check("n3_rdy",  n3_req_rdy, rdy ? exp_gnt : 3'b000);
        check("n3_busy", n3_busy, exp_busy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] seq_gnt [5];
        int  g;
        bit  ev;
        int  dsrc;
        logic [N-1:0] exp_gnt;

        seq_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        n3_req_vld  = '0;
        n3_req_last = '0;
        n3_req_data = {8'h32, 8'h31, 8'h30};
        n3_out_rdy  = 1'b0;
        #3;
        do_reset();

        // All four requesting single-beat packets: strict rotation.
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            req_vld  = '1;
            req_last = '1;
            out_rdy  = 1'b1;
            for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'h100 + i + 16*c;
            @(negedge clk);
            check("rot_gnt",  out_gnt, seq_gnt[c]);
            check("rot_busy", busy, 0);
            for (int i = 0; i < N; i++)
                if (seq_gnt[c][i]) check("rot_data", out_data, 32'h100 + i + 16*c);
            @(posedge clk); #1;
        end
        req_vld = '0;

        // N=3: rotation wraps, a 2-beat packet from 2 locks out 0, then ptr wraps to 0.
        do_reset();
        @(posedge clk); #1;
        step3(3'b111, 3'b111, 1'b1, 3'b001, 1'b0);
        step3(3'b111, 3'b111, 1'b1, 3'b010, 1'b0);
        step3(3'b111, 3'b111, 1'b1, 3'b100, 1'b0);
        step3(3'b011, 3'b011, 1'b1, 3'b001, 1'b0);
        step3(3'b100, 3'b000, 1'b1, 3'b100, 1'b0);
        step3(3'b011, 3'b100, 1'b1, 3'b000, 1'b1);
        step3(3'b111, 3'b100, 1'b1, 3'b100, 1'b1);
        step3(3'b011, 3'b011, 1'b1, 3'b001, 1'b0);
        n3_req_vld = '0;
        n3_out_rdy = 1'b0;

        // Random traffic against the model.
        do_reset();
        @(posedge clk); #1;
        gen_inputs();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            ev = 0;
            g  = 0;
            if (m_lock) begin
                g  = m_owner;
                ev = req_vld[g];
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (!ev && req_vld[(m_ptr + k) % N]) begin
                        ev = 1;
                        g  = (m_ptr + k) % N;
                    end
                end
            end
            exp_gnt = ev ? (N'(1) << g) : '0;

            @(negedge clk);
            check("gnt",  out_gnt, exp_gnt);
            check("vld",  out_vld, ev);
            check("rdy",  req_rdy, out_rdy ? exp_gnt : '0);
            check("busy", busy, m_lock);
            if (ev) begin
                check("data", out_data, req_data[g*W +: W]);
                check("last", out_last, req_last[g]);
            end
            if (out_vld && out_rdy) begin
                dsrc = 0;
                for (int i = 0; i < N; i++) if (out_gnt[i]) dsrc = i;
                if (sb_in_pkt) check("no_interleave", dsrc, sb_src);
            end

            @(posedge clk); #1;
            if (ev) begin
                if (out_rdy) begin
                    sb_in_pkt = !req_last[g];
                    sb_src    = g;
                end
                if (!m_lock) begin
                    if (out_rdy && req_last[g]) m_ptr = (g + 1) % N;
                    else begin
                        m_lock  = 1;
                        m_owner = g;
                    end
                end else if (out_rdy && req_last[g]) begin
                    m_lock = 0;
                    m_ptr  = (g + 1) % N;
                end
                if (out_rdy) begin
                    req_vld[g] = 1'b0;
                    rem_len[g] = rem_len[g] - 1;
                    if (rem_len[g] == 0) rem_len[g] = $urandom_range(1, 4);
                end
            end

            if (cyc % 400 == 200) begin
                do_reset();
                gen_inputs();
            end else begin
                gen_inputs();
                if (cyc % 400 == 199) out_rdy = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
